dma_packet_deframer: RTL and testbench

Hardware-side receiver for the software-to-hardware DMA transport: it takes the raw word stream written by the host send path, checks and strips the per-transfer header, and re-emits each payload as a single-packet FrameLink frame toward the DUT input. It sits between the DMA channel output and the DUT, and reports length errors, sequence errors and a forwarded-packet count to the host status registers.

---
 rtl/dma_deframer_pkg.sv | 28 ++
 rtl/dma_packet_deframer_if.sv | 36 +++
 rtl/dma_packet_deframer_fl_out_reg.sv | 54 +++++
 rtl/dma_packet_deframer.sv | 134 +++++++++++++
 tb/tb_dma_packet_deframer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_deframer_pkg.sv
// Shared constants and types for the DMA packet deframer: header field layout,
// FSM state encoding and the byte-index width helper.
package dma_deframer_pkg;

  localparam int LEN_LSB = 0;
  localparam int LEN_W   = 16;
  localparam int SEQ_LSB = 16;
  localparam int SEQ_W   = 16;

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    DATA    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  // log2 of bytes per word; width of the FrameLink REM field.
  function automatic int rem_width(input int data_width);
    int bytes;
    int w;
    bytes = data_width / 8;
    w = 0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) < bytes) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dma_packet_deframer_if.sv
// DMA input stream and FrameLink output stream of the deframer, bundled as one interface.
interface dma_packet_deframer_if
  import dma_deframer_pkg::*;
#(
  parameter int DATA_WIDTH = 64
);
  localparam int REM_W = rem_width(DATA_WIDTH);

  // Both streams use active-low valid (src_rdy_n) / ready (dst_rdy_n); a word moves on a
  // rising edge where both are 0, and a source never withdraws or changes a word it offered.
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_src_rdy_n;
  logic                  rx_dst_rdy_n;

  logic [DATA_WIDTH-1:0] tx_data;
  logic [REM_W-1:0]      tx_rem;
  logic                  tx_sof_n;
  logic                  tx_sop_n;
  logic                  tx_eof_n;
  logic                  tx_eop_n;
  logic                  tx_src_rdy_n;
  logic                  tx_dst_rdy_n;

  modport master (
    input  rx_data, rx_src_rdy_n, tx_dst_rdy_n,
    output rx_dst_rdy_n, tx_data, tx_rem, tx_sof_n, tx_sop_n, tx_eof_n, tx_eop_n,
           tx_src_rdy_n
  );

  modport slave (
    output rx_data, rx_src_rdy_n, tx_dst_rdy_n,
    input  rx_dst_rdy_n, tx_data, tx_rem, tx_sof_n, tx_sop_n, tx_eof_n, tx_eop_n,
           tx_src_rdy_n
  );

endinterface

// File: rtl/dma_packet_deframer_fl_out_reg.sv
// One-entry FrameLink output register: holds a word and its flags until the DUT takes it.
module fl_out_reg #(
  parameter int DW = 64,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic [RW-1:0] load_rem,
  input  logic          load_sof,
  input  logic          load_eof,
  input  logic          dst_rdy_n,
  output logic [DW-1:0] data,
  output logic [RW-1:0] rem,
  output logic          sof_n,
  output logic          sop_n,
  output logic          eof_n,
  output logic          eop_n,
  output logic          src_rdy_n,
  output logic          can_accept,
  output logic          eof_sent
);

  logic take;

  assign take       = !src_rdy_n && !dst_rdy_n;
  assign can_accept = src_rdy_n || !dst_rdy_n;
  assign eof_sent   = take && !eof_n;
  assign sop_n      = sof_n;
  assign eop_n      = eof_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      data      <= '0;
      rem       <= '0;
      sof_n     <= 1'b1;
      eof_n     <= 1'b1;
      src_rdy_n <= 1'b1;
    end else if (load) begin
      data      <= load_data;
      rem       <= load_rem;
      sof_n     <= !load_sof;
      eof_n     <= !load_eof;
      src_rdy_n <= 1'b0;
    end else if (take) begin
      // Data is left in place; only the valid and framing flags drop.
      sof_n     <= 1'b1;
      eof_n     <= 1'b1;
      src_rdy_n <= 1'b1;
    end
  end

endmodule

// File: rtl/dma_packet_deframer.sv
// Strips and checks the per-transfer DMA header and re-emits each payload as one
// FrameLink frame, reporting length/sequence errors and a forwarded-frame count.
module dma_packet_deframer
  import dma_deframer_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_LEN    = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  dma_packet_deframer_if.master  bus,
  output logic                   err_len,
  output logic                   err_seq,
  output logic [31:0]            pkt_cnt,
  output state_t                 state
);

  localparam int          REM_W     = rem_width(DATA_WIDTH);
  localparam logic [15:0] B16       = 16'(DATA_WIDTH / 8);
  localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

  state_t      state_n;
  logic [15:0] rem_bytes, rem_n, rem_m1;
  logic [15:0] exp_seq, exp_seq_n;
  logic        first, first_n;
  logic        err_len_n, err_seq_n;
  logic        load, ld_sof, ld_eof;
  logic [REM_W-1:0] ld_rem;
  logic        can_accept, eof_sent, rx_fire;
  logic [LEN_W-1:0] hdr_len;
  logic [SEQ_W-1:0] hdr_seq;

  assign hdr_len = bus.rx_data[LEN_LSB +: LEN_W];
  assign hdr_seq = bus.rx_data[SEQ_LSB +: SEQ_W];
  assign rem_m1  = rem_bytes - 16'd1;
  assign rx_fire = !bus.rx_src_rdy_n && !bus.rx_dst_rdy_n;

  always_comb begin
    if (reset)              bus.rx_dst_rdy_n = 1'b1;
    else if (state == DATA) bus.rx_dst_rdy_n = !can_accept;
    else                    bus.rx_dst_rdy_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HDR;
      rem_bytes <= '0;
      exp_seq   <= '0;
      first     <= 1'b0;
      err_len   <= 1'b0;
      err_seq   <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      state     <= state_n;
      rem_bytes <= rem_n;
      exp_seq   <= exp_seq_n;
      first     <= first_n;
      err_len   <= err_len_n;
      err_seq   <= err_seq_n;
      if (eof_sent) pkt_cnt <= pkt_cnt + 32'd1;
    end
  end

  always_comb begin
    state_n   = state;
    rem_n     = rem_bytes;
    first_n   = first;
    exp_seq_n = exp_seq;
    err_len_n = 1'b0;
    err_seq_n = 1'b0;
    load      = 1'b0;
    ld_sof    = 1'b0;
    ld_eof    = 1'b0;
    ld_rem    = '0;
    if (rx_fire) begin
      case (state)
        HDR: begin
          // The expected seq follows whatever arrived so one gap is reported once.
          err_seq_n = (hdr_seq != exp_seq);
          exp_seq_n = hdr_seq + 16'd1;
          if (hdr_len == '0) begin
            err_len_n = 1'b1;
          end else if (hdr_len > MAX_LEN16) begin
            err_len_n = 1'b1;
            rem_n     = hdr_len;
            state_n   = DISCARD;
          end else begin
            rem_n   = hdr_len;
            first_n = 1'b1;
            state_n = DATA;
          end
        end
        DATA: begin
          load    = 1'b1;
          ld_sof  = first;
          first_n = 1'b0;
          if (rem_bytes <= B16) begin
            ld_eof  = 1'b1;
            ld_rem  = rem_m1[REM_W-1:0];
            state_n = HDR;
          end else begin
            rem_n = rem_bytes - B16;
          end
        end
        DISCARD: begin
          if (rem_bytes <= B16) state_n = HDR;
          else                  rem_n   = rem_bytes - B16;
        end
        default: state_n = HDR;
      endcase
    end
  end

  fl_out_reg #(.DW(DATA_WIDTH), .RW(REM_W)) u_out (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_data  (bus.rx_data),
    .load_rem   (ld_rem),
    .load_sof   (ld_sof),
    .load_eof   (ld_eof),
    .dst_rdy_n  (bus.tx_dst_rdy_n),
    .data       (bus.tx_data),
    .rem        (bus.tx_rem),
    .sof_n      (bus.tx_sof_n),
    .sop_n      (bus.tx_sop_n),
    .eof_n      (bus.tx_eof_n),
    .eop_n      (bus.tx_eop_n),
    .src_rdy_n  (bus.tx_src_rdy_n),
    .can_accept (can_accept),
    .eof_sent   (eof_sent)
  );

endmodule

// File: tb/tb_dma_packet_deframer.sv
// Directed bench for dma_packet_deframer: header checking, framing, back-pressure and reset.
module tb_dma_packet_deframer;
  import dma_deframer_pkg::*;

  localparam int DW = 64;
  localparam int W  = 2 + 3 + DW;

  logic        clk;
  logic        reset;
  logic        err_len, err_seq;
  logic [31:0] pkt_cnt;
  state_t      state;

  dma_packet_deframer_if #(.DATA_WIDTH(DW)) bus ();

  dma_packet_deframer #(.DATA_WIDTH(DW), .MAX_LEN(4096)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .err_len (err_len),
    .err_seq (err_seq),
    .pkt_cnt (pkt_cnt),
    .state   (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int err_len_cnt = 0, err_seq_cnt = 0, flag_err = 0, hold_err = 0, ready_err = 0;
  int stall_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [W-1:0] prev_word;
  logic         prev_stall = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [W-1:0] cur;
    cur = {bus.tx_sof_n, bus.tx_eof_n, bus.tx_rem, bus.tx_data};
    if (!reset) begin
      if (!bus.tx_src_rdy_n && !bus.tx_dst_rdy_n) obs_q.push_back(cur);
      if (err_len) err_len_cnt++;
      if (err_seq) err_seq_cnt++;
      if (bus.tx_sop_n !== bus.tx_sof_n || bus.tx_eop_n !== bus.tx_eof_n) flag_err++;
      if (prev_stall && cur !== prev_word) hold_err++;
      if (!bus.tx_src_rdy_n && bus.tx_dst_rdy_n) begin
        stall_cnt++;
        if (state == DATA && !bus.rx_dst_rdy_n) ready_err++;
      end
      prev_stall = !bus.tx_src_rdy_n && bus.tx_dst_rdy_n;
      prev_word  = cur;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic [63:0] hdr(input logic [15:0] len, input logic [15:0] seq);
    return {32'hC0DE_BEEF, seq, len};
  endfunction

  // driver tasks; called on a falling edge, return on the falling edge after acceptance
  task automatic rx_word(input logic [63:0] d);
    int t;
    bus.rx_data      = d;
    bus.rx_src_rdy_n = 1'b0;
    t = 0;
    while (bus.rx_dst_rdy_n && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("rx_accept_timeout", 1, 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rx_idle();
    bus.rx_src_rdy_n = 1'b1;
  endtask

  task automatic send_frame(input logic [15:0] len, input logic [15:0] seq, input int n,
                            input logic [63:0] base, input logic [2:0] last_rem);
    rx_word(hdr(len, seq));
    for (int i = 0; i < n; i++) begin
      rx_word(base + 64'(i));
      exp_q.push_back({(i == 0) ? 1'b0 : 1'b1, (i == n - 1) ? 1'b0 : 1'b1,
                       (i == n - 1) ? last_rem : 3'd0, base + 64'(i)});
    end
    rx_idle();
  endtask

  task automatic drain_check(input string tag);
    int t;
    t = 0;
    while (!bus.tx_src_rdy_n && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check({tag, "_drain_timeout"}, 1, 0);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check({tag, "_word"}, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int el0, es0;
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    reset            = 1'b1;
    bus.rx_data      = '0;
    bus.rx_src_rdy_n = 1'b1;
    bus.tx_dst_rdy_n = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_rx_rdy_n", bus.rx_dst_rdy_n, 1);
    check("rst_tx_src_rdy_n", bus.tx_src_rdy_n, 1);
    check("rst_tx_flags", {bus.tx_sof_n, bus.tx_sop_n, bus.tx_eof_n, bus.tx_eop_n}, 4'hF);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_tx_rem", bus.tx_rem, 0);
    check("rst_err", {err_len, err_seq}, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_state", 128'(state), 128'(HDR));
    reset = 1'b0;
    @(negedge clk);

    // len=20 seq=0: three words, last REM = 3
    send_frame(16'd20, 16'd0, 3, 64'h1111_2222_3333_0000, 3'd3);
    drain_check("len20");
    check("len20_pkt_cnt", pkt_cnt, 1);
    check("len20_errs", err_len_cnt + err_seq_cnt, 0);

    // len=8 seq=1 single word; stalled to check one-cycle latency and flags
    bus.tx_dst_rdy_n = 1'b1;
    rx_word(hdr(16'd8, 16'd1));
    check("len8_hdr_no_tx", bus.tx_src_rdy_n, 1);
    rx_word(64'hAAAA_5555_0000_0008);
    rx_idle();
    exp_q.push_back({1'b0, 1'b0, 3'd7, 64'hAAAA_5555_0000_0008});
    check("len8_latency_valid", bus.tx_src_rdy_n, 0);
    check("len8_sof_eof_rem", {bus.tx_sof_n, bus.tx_eof_n, bus.tx_rem}, {1'b0, 1'b0, 3'd7});
    @(negedge clk);
    bus.tx_dst_rdy_n = 1'b0;
    drain_check("len8");
    check("len8_pkt_cnt", pkt_cnt, 2);

    // len=0 seq=5: both errors in the same cycle, no TX, then seq=6 resyncs
    rx_word(hdr(16'd0, 16'd5));
    rx_idle();
    check("len0_errs_pulse", {err_len, err_seq}, 2'b11);
    check("len0_no_tx", bus.tx_src_rdy_n, 1);
    @(negedge clk);
    check("len0_errs_clear", {err_len, err_seq}, 2'b00);
    es0 = err_seq_cnt;
    send_frame(16'd8, 16'd6, 1, 64'h6666_0000_0000_0006, 3'd7);
    drain_check("seq6");
    check("seq6_no_err_seq", err_seq_cnt - es0, 0);
    check("seq6_pkt_cnt", pkt_cnt, 3);

    // oversize header: 4097 bytes are 513 dropped words, then a 2-word frame
    el0 = err_len_cnt;
    es0 = err_seq_cnt;
    rx_word(hdr(16'd4097, 16'd7));
    for (int i = 0; i < 513; i++) rx_word(64'hDEAD_0000_0000_0000 + 64'(i));
    rx_idle();
    check("discard_state_hdr", 128'(state), 128'(HDR));
    send_frame(16'd16, 16'd8, 2, 64'h1616_0000_0000_0000, 3'd7);
    drain_check("after_discard");
    check("discard_err_len_once", err_len_cnt - el0, 1);
    check("discard_no_err_seq", err_seq_cnt - es0, 0);
    check("discard_pkt_cnt", pkt_cnt, 4);

    // back-pressure on a 4-word frame
    bus.tx_dst_rdy_n = 1'b1;
    stall_cnt = 0;
    fork
      send_frame(16'd32, 16'd9, 4, 64'hB0B0_0000_0000_0000, 3'd7);
      begin
        int t;
        t = 0;
        while (bus.tx_src_rdy_n && t < 50) begin
          @(negedge clk);
          t++;
        end
        for (int i = 0; i < 5; i++) begin
          @(posedge clk);
          #1 bus.tx_dst_rdy_n = pat[i];
        end
        @(posedge clk);
        #1 bus.tx_dst_rdy_n = 1'b0;
      end
    join
    @(negedge clk);
    drain_check("bp");
    check("bp_stalled", stall_cnt >= 3, 1);
    check("bp_hold_stable", hold_err, 0);
    check("bp_rx_blocked", ready_err, 0);
    check("bp_pkt_cnt", pkt_cnt, 5);

    // reset after word 2 of a 4-word frame
    es0 = err_seq_cnt;
    rx_word(hdr(16'd32, 16'd10));
    rx_word(64'hCC00_0000_0000_0000);
    exp_q.push_back({1'b0, 1'b1, 3'd0, 64'hCC00_0000_0000_0000});
    rx_word(64'hCC00_0000_0000_0001);
    exp_q.push_back({1'b1, 1'b1, 3'd0, 64'hCC00_0000_0000_0001});
    rx_idle();
    @(negedge clk);
    check("mid_pkt_cnt_before", pkt_cnt, 5);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_rx_rdy_n", bus.rx_dst_rdy_n, 1);
    check("mid_rst_pkt_cnt", pkt_cnt, 0);
    check("mid_rst_state", 128'(state), 128'(HDR));
    check("mid_rst_no_tx", bus.tx_src_rdy_n, 1);
    reset = 1'b0;
    @(negedge clk);
    drain_check("mid_old");
    send_frame(16'd8, 16'd0, 1, 64'hEEEE_0000_0000_0000, 3'd7);
    drain_check("mid_new");
    check("mid_new_pkt_cnt", pkt_cnt, 1);
    check("mid_new_no_err_seq", err_seq_cnt - es0, 0);
    check("all_sop_eop_flags", flag_err, 0);
    check("all_hold_stable", hold_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
